// File: rtl/araddr_issue_ctrl.sv
// araddr_issue_ctrl
// -----------------------------------------------------------------------------
// Pops {len, addr} burst descriptors from the read-address FIFO and issues them
// on the AXI4 AR channel. Issue is throttled by a count of accepted-but-not-yet-
// completed read bursts. Everything runs in the FIFO read clock domain.
//
// Build option:
//   ARADDR_BOUNDARY_SPLIT_EN  defined   : a descriptor whose burst would cross a
//                                         4 KB page is issued as two bursts, and
//                                         two free slots are kept in reserve.
//                             undefined : descriptors are issued unmodified as
//                                         a single burst each.
//
// Ports:
//   rd_clk, rd_rst          clock and asynchronous active-high reset
//   fifo_rd_data            descriptor {len, addr}, valid the cycle after a pop
//   fifo_rd_empty           FIFO empty flag
//   fifo_rd_en              registered single-cycle pop strobe
//   m_araddr/m_arlen        registered AR payload (len = beats-1)
//   m_arsize/m_arburst      constants: c_SIZE and INCR
//   m_arvalid/m_arready     AR handshake (m_arvalid registered)
//   r_burst_done            one pulse per completed read burst
//   outstanding             current outstanding-burst count
//   busy                    high whenever the controller is not IDLE
//
// Timing: the pop decision is made one cycle ahead so that fifo_rd_en comes
// straight from a flop. A cycle with fifo_rd_en high is still an IDLE cycle;
// the popped data is captured in LOAD on the next cycle and m_arvalid rises on
// the cycle after that. With m_arready high this gives one unsplit burst every
// three cycles, because the next pop is decided during the handshake cycle.
// -----------------------------------------------------------------------------
module araddr_issue_ctrl #(
  parameter int c_ADDR_WIDTH      = 32,
  parameter int c_LEN_WIDTH       = 8,
  parameter int c_SIZE            = 5,
  parameter int c_MAX_OUTSTANDING = 8
) (
  input  logic                                   rd_clk,
  input  logic                                   rd_rst,
  input  logic [c_LEN_WIDTH+c_ADDR_WIDTH-1:0]    fifo_rd_data,
  input  logic                                   fifo_rd_empty,
  output logic                                   fifo_rd_en,
  output logic [c_ADDR_WIDTH-1:0]                m_araddr,
  output logic [c_LEN_WIDTH-1:0]                 m_arlen,
  output logic [2:0]                             m_arsize,
  output logic [1:0]                             m_arburst,
  output logic                                   m_arvalid,
  input  logic                                   m_arready,
  input  logic                                   r_burst_done,
  output logic [$clog2(c_MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                   busy
);

  localparam int OUT_W = $clog2(c_MAX_OUTSTANDING + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

`ifdef ARADDR_BOUNDARY_SPLIT_EN
  // Keep two slots free so that both halves of a split always fit.
  localparam int POP_LIMIT = c_MAX_OUTSTANDING - 2;
`else
  localparam int POP_LIMIT = c_MAX_OUTSTANDING - 1;
`endif

  localparam logic [OUT_W-1:0] POP_LIMIT_C = OUT_W'(POP_LIMIT);
  localparam logic [OUT_W-1:0] MAX_C       = OUT_W'(c_MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] ONE_C       = {{(OUT_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0] ZERO_C      = {OUT_W{1'b0}};

  logic [1:0]              state_r;
  logic [1:0]              state_nx_s;
  logic                    fifo_rd_en_r;
  logic                    pop_nx_s;
  logic [c_ADDR_WIDTH-1:0] araddr_r;
  logic [c_LEN_WIDTH-1:0]  arlen_r;
  logic                    arvalid_r;
  logic                    busy_r;
  logic                    hs_s;
  logic                    split_pending_s;
  logic [OUT_W-1:0]        outstanding_r;
  logic [OUT_W:0]          count_after_s;
  logic [c_ADDR_WIDTH-1:0] desc_addr_s;
  logic [c_LEN_WIDTH-1:0]  desc_len_s;
  logic [c_ADDR_WIDTH-1:0] first_addr_s;
  logic [c_LEN_WIDTH-1:0]  first_len_s;

  assign desc_addr_s = fifo_rd_data[c_ADDR_WIDTH-1:0];
  assign desc_len_s  = fifo_rd_data[c_LEN_WIDTH+c_ADDR_WIDTH-1:c_ADDR_WIDTH];

`ifdef ARADDR_BOUNDARY_SPLIT_EN
  localparam logic [c_ADDR_WIDTH-1:0] ALIGN_MASK = {c_ADDR_WIDTH{1'b1}} << c_SIZE;
  localparam logic [c_ADDR_WIDTH-1:0] PAGE_BYTES = {{(c_ADDR_WIDTH-13){1'b0}}, 13'h1000};

  logic [c_ADDR_WIDTH-1:0] aligned_addr_s;
  logic [c_ADDR_WIDTH-1:0] second_addr_s;
  logic [c_ADDR_WIDTH-1:0] second_addr_r;
  logic [c_LEN_WIDTH-1:0]  second_len_s;
  logic [c_LEN_WIDTH-1:0]  second_len_r;
  logic [13:0]             offset_s;
  logic [13:0]             bytes_s;
  logic [13:0]             first_beats_s;
  logic                    cross_s;
  logic                    split_pending_r;

  // 4 KB page split of the descriptor presented during LOAD (14-bit unsigned)
  always_comb begin
    aligned_addr_s = desc_addr_s & ALIGN_MASK;
    offset_s       = {2'b00, aligned_addr_s[11:0]};
    bytes_s        = (14'(desc_len_s) + 14'd1) << c_SIZE;
    first_beats_s  = (14'd4096 - offset_s) >> c_SIZE;
    cross_s        = ((offset_s + bytes_s) > 14'd4096);
    second_addr_s  = {aligned_addr_s[c_ADDR_WIDTH-1:12], 12'h000} + PAGE_BYTES;
    first_addr_s   = aligned_addr_s;
    if (cross_s) begin
      first_len_s  = c_LEN_WIDTH'(first_beats_s - 14'd1);
      second_len_s = desc_len_s - c_LEN_WIDTH'(first_beats_s);
    end else begin
      first_len_s  = desc_len_s;
      second_len_s = {c_LEN_WIDTH{1'b0}};
    end
  end

  assign split_pending_s = split_pending_r;
`else
  assign first_addr_s    = desc_addr_s;
  assign first_len_s     = desc_len_s;
  assign split_pending_s = 1'b0;
`endif

  // next-state decode and the pop decision for the following cycle
  always_comb begin
    hs_s = arvalid_r & m_arready;
    case (state_r)
      ST_IDLE: begin
        if (fifo_rd_en_r) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nx_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (hs_s && !split_pending_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_ISSUE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase

    // Count as it will stand once this cycle's handshake lands; a concurrent
    // r_burst_done is ignored here, which can only delay a pop by one cycle.
    if (hs_s) begin
      count_after_s = {1'b0, outstanding_r} + {{OUT_W{1'b0}}, 1'b1};
    end else begin
      count_after_s = {1'b0, outstanding_r};
    end

    if ((state_nx_s == ST_IDLE) && !fifo_rd_empty &&
        (count_after_s <= {1'b0, POP_LIMIT_C})) begin
      pop_nx_s = 1'b1;
    end else begin
      pop_nx_s = 1'b0;
    end
  end

  // state, pop strobe and AR channel payload registers
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_r         <= ST_IDLE;
      fifo_rd_en_r    <= 1'b0;
      araddr_r        <= {c_ADDR_WIDTH{1'b0}};
      arlen_r         <= {c_LEN_WIDTH{1'b0}};
      arvalid_r       <= 1'b0;
      busy_r          <= 1'b0;
`ifdef ARADDR_BOUNDARY_SPLIT_EN
      split_pending_r <= 1'b0;
      second_addr_r   <= {c_ADDR_WIDTH{1'b0}};
      second_len_r    <= {c_LEN_WIDTH{1'b0}};
`endif
    end else begin
      state_r      <= state_nx_s;
      fifo_rd_en_r <= pop_nx_s;
      busy_r       <= (state_nx_s != ST_IDLE);
      case (state_r)
        ST_LOAD: begin
          araddr_r        <= first_addr_s;
          arlen_r         <= first_len_s;
          arvalid_r       <= 1'b1;
`ifdef ARADDR_BOUNDARY_SPLIT_EN
          split_pending_r <= cross_s;
          second_addr_r   <= second_addr_s;
          second_len_r    <= second_len_s;
`endif
        end
        ST_ISSUE: begin
          if (hs_s) begin
            if (split_pending_s) begin
`ifdef ARADDR_BOUNDARY_SPLIT_EN
              araddr_r        <= second_addr_r;
              arlen_r         <= second_len_r;
              split_pending_r <= 1'b0;
`endif
            end else begin
              arvalid_r <= 1'b0;
            end
          end
        end
        default: begin
          arvalid_r <= arvalid_r;
        end
      endcase
    end
  end

  // outstanding bursts: +1 per AR handshake, -1 per completed burst, saturating
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      outstanding_r <= ZERO_C;
    end else begin
      case ({hs_s, r_burst_done})
        2'b10: begin
          if (outstanding_r < MAX_C) begin
            outstanding_r <= outstanding_r + ONE_C;
          end else begin
            outstanding_r <= outstanding_r;
          end
        end
        2'b01: begin
          if (outstanding_r != ZERO_C) begin
            outstanding_r <= outstanding_r - ONE_C;
          end else begin
            outstanding_r <= outstanding_r;
          end
        end
        default: begin
          outstanding_r <= outstanding_r;
        end
      endcase
    end
  end

  assign fifo_rd_en  = fifo_rd_en_r;
  assign m_araddr    = araddr_r;
  assign m_arlen     = arlen_r;
  assign m_arvalid   = arvalid_r;
  assign m_arsize    = 3'(c_SIZE);
  assign m_arburst   = 2'b01;
  assign outstanding = outstanding_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_araddr_issue_ctrl.sv
// Directed testbench for araddr_issue_ctrl with a small FIFO model and an AR
// handshake counter. Expected values are hand-computed constants.
module tb_araddr_issue_ctrl;

  localparam int AW = 32;
  localparam int LW = 8;
  localparam int SZ = 5;
  localparam int MO = 8;
  localparam int OW = $clog2(MO + 1);
`ifdef ARADDR_BOUNDARY_SPLIT_EN
  localparam int LIMIT = MO - 1;  // popping stops once this many are outstanding
`else
  localparam int LIMIT = MO;
`endif

  logic          clk = 1'b0;
  logic          rd_rst;
  logic [LW+AW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic          fifo_rd_en;
  logic [AW-1:0] m_araddr;
  logic [LW-1:0] m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arvalid;
  logic          m_arready;
  logic          r_burst_done;
  logic [OW-1:0] outstanding;
  logic          busy;

  araddr_issue_ctrl #(
    .c_ADDR_WIDTH(AW), .c_LEN_WIDTH(LW), .c_SIZE(SZ), .c_MAX_OUTSTANDING(MO)
  ) dut (
    .rd_clk(clk), .rd_rst(rd_rst),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty), .fifo_rd_en(fifo_rd_en),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .r_burst_done(r_burst_done),
    .outstanding(outstanding), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a pop
  logic [LW+AW-1:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_empty_n = 0;
  assign fifo_rd_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wr_ptr == rd_ptr) begin
        pop_empty_n <= pop_empty_n + 1;
      end else begin
        fifo_rd_data <= fifo_mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1;
      end
    end
  end

  // AR handshake counter
  int hs_n = 0;
  always @(posedge clk) begin
    if (m_arvalid && m_arready) hs_n <= hs_n + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [LW-1:0] len, input logic [AW-1:0] addr);
    fifo_mem[wr_ptr] = {len, addr};
    wr_ptr = wr_ptr + 1;
  endtask

  // wait (bounded) for a pop; returns at the negedge where fifo_rd_en is seen
  task automatic wait_pop(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!seen) begin
        @(negedge clk);
        seen = fifo_rd_en;
      end
    end
    check_val(tag, {63'd0, fifo_rd_en}, 64'd1);
  endtask

  task automatic apply_reset();
    rd_rst = 1'b1;
    @(negedge clk);
    rd_rst = 1'b0;
  endtask

  initial begin
    int hs0;
    logic [LW-1:0] rst_len;
    logic [AW-1:0] rst_addr;

    rd_rst       = 1'b1;
    m_arready    = 1'b0;
    r_burst_done = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_fifo_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check_val("rst_arvalid", {63'd0, m_arvalid}, 64'd0);
    check_val("rst_araddr", {32'd0, m_araddr}, 64'd0);
    check_val("rst_arlen", {56'd0, m_arlen}, 64'd0);
    check_val("rst_outstanding", {60'd0, outstanding}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("arsize", {61'd0, m_arsize}, 64'd5);
    check_val("arburst", {62'd0, m_arburst}, 64'd1);
    rd_rst = 1'b0;

    // single descriptor: pop at T, LOAD at T+1, valid at T+2
    m_arready = 1'b1;
    push(8'd15, 32'h0000_1000);
    wait_pop("t1_pop");
    @(negedge clk);
    check_val("t1_valid_t1", {63'd0, m_arvalid}, 64'd0);
    check_val("t1_busy_load", {63'd0, busy}, 64'd1);
    check_val("t1_pop_once", {63'd0, fifo_rd_en}, 64'd0);
    @(negedge clk);
    check_val("t1_valid_t2", {63'd0, m_arvalid}, 64'd1);
    check_val("t1_addr", {32'd0, m_araddr}, 64'h1000);
    check_val("t1_len", {56'd0, m_arlen}, 64'd15);
    @(negedge clk);
    check_val("t1_valid_drop", {63'd0, m_arvalid}, 64'd0);
    check_val("t1_outstanding", {60'd0, outstanding}, 64'd1);
    check_val("t1_busy_idle", {63'd0, busy}, 64'd0);

    // two queued descriptors: one burst every three cycles
    push(8'd3, 32'h0000_2000);
    push(8'd1, 32'h0000_3000);
    wait_pop("t2_pop_a");
    @(negedge clk);
    check_val("t2_no_pop_t1", {63'd0, fifo_rd_en}, 64'd0);
    @(negedge clk);
    check_val("t2_a_valid", {63'd0, m_arvalid}, 64'd1);
    check_val("t2_a_addr", {32'd0, m_araddr}, 64'h2000);
    check_val("t2_a_len", {56'd0, m_arlen}, 64'd3);
    check_val("t2_no_pop_t2", {63'd0, fifo_rd_en}, 64'd0);
    @(negedge clk);
    check_val("t2_pop_b_t3", {63'd0, fifo_rd_en}, 64'd1);
    repeat (2) @(negedge clk);
    check_val("t2_b_valid", {63'd0, m_arvalid}, 64'd1);
    check_val("t2_b_addr", {32'd0, m_araddr}, 64'h3000);
    check_val("t2_b_len", {56'd0, m_arlen}, 64'd1);
    @(negedge clk);
    check_val("t2_outstanding", {60'd0, outstanding}, 64'd3);

    // completion decrements
    r_burst_done = 1'b1;
    @(negedge clk);
    r_burst_done = 1'b0;
    check_val("dec_outstanding", {60'd0, outstanding}, 64'd2);

    // burst ending exactly on the 4 KB page: single burst
    push(8'd3, 32'h0000_0F80);
    wait_pop("edge_pop");
    repeat (2) @(negedge clk);
    check_val("edge_valid", {63'd0, m_arvalid}, 64'd1);
    check_val("edge_addr", {32'd0, m_araddr}, 64'h0F80);
    check_val("edge_len", {56'd0, m_arlen}, 64'd3);
    @(negedge clk);
    check_val("edge_no_second", {63'd0, m_arvalid}, 64'd0);
    check_val("edge_outstanding", {60'd0, outstanding}, 64'd3);

    // backpressure for 5 cycles, then handshake together with a completion
    m_arready = 1'b0;
    push(8'd2, 32'h0000_4000);
    wait_pop("bp_pop");
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_val("bp_valid_held", {63'd0, m_arvalid}, 64'd1);
      check_val("bp_addr_held", {32'd0, m_araddr}, 64'h4000);
      check_val("bp_len_held", {56'd0, m_arlen}, 64'd2);
      @(negedge clk);
    end
    hs0 = hs_n;
    m_arready    = 1'b1;
    r_burst_done = 1'b1;
    @(negedge clk);
    m_arready    = 1'b0;
    r_burst_done = 1'b0;
    check_val("bp_valid_drop", {63'd0, m_arvalid}, 64'd0);
    check_val("both_outstanding", {60'd0, outstanding}, 64'd3);
    @(negedge clk);
    check_val("bp_one_handshake", 64'(hs_n - hs0), 64'd1);

`ifdef ARADDR_BOUNDARY_SPLIT_EN
    // crossing descriptor: two halves on consecutive cycles
    m_arready = 1'b1;
    push(8'd7, 32'h0000_0F80);
    wait_pop("split_pop");
    repeat (2) @(negedge clk);
    check_val("split_a_valid", {63'd0, m_arvalid}, 64'd1);
    check_val("split_a_addr", {32'd0, m_araddr}, 64'h0F80);
    check_val("split_a_len", {56'd0, m_arlen}, 64'd3);
    @(negedge clk);
    check_val("split_b_valid", {63'd0, m_arvalid}, 64'd1);
    check_val("split_b_addr", {32'd0, m_araddr}, 64'h1000);
    check_val("split_b_len", {56'd0, m_arlen}, 64'd3);
    @(negedge clk);
    check_val("split_done", {63'd0, m_arvalid}, 64'd0);
    check_val("split_outstanding", {60'd0, outstanding}, 64'd5);
`endif

    // completion at zero is ignored
    apply_reset();
    r_burst_done = 1'b1;
    @(negedge clk);
    r_burst_done = 1'b0;
    @(negedge clk);
    check_val("sat_zero", {60'd0, outstanding}, 64'd0);

    // throttle: 10 queued, no completions
    m_arready = 1'b1;
    hs0 = hs_n;
    for (int i = 0; i < 10; i++) push(8'd0, 32'h0001_0000 + 32'(i) * 32'h1000);
    repeat (60) @(negedge clk);
    check_val("thr_outstanding", {60'd0, outstanding}, 64'(LIMIT));
    check_val("thr_handshakes", 64'(hs_n - hs0), 64'(LIMIT));
    check_val("thr_fifo_left", 64'(wr_ptr - rd_ptr), 64'(10 - LIMIT));
    check_val("thr_no_pop", {63'd0, fifo_rd_en}, 64'd0);
    r_burst_done = 1'b1;
    @(negedge clk);
    r_burst_done = 1'b0;
    wait_pop("thr_resume_pop");
    repeat (6) @(negedge clk);
    check_val("thr_outstanding2", {60'd0, outstanding}, 64'(LIMIT));
    check_val("thr_handshakes2", 64'(hs_n - hs0), 64'(LIMIT + 1));
    check_val("thr_fifo_left2", 64'(wr_ptr - rd_ptr), 64'(10 - LIMIT - 1));
    wr_ptr = rd_ptr;  // drop the remaining descriptors

    // reset while the first burst is held
    apply_reset();
    m_arready = 1'b0;
`ifdef ARADDR_BOUNDARY_SPLIT_EN
    rst_len  = 8'd7;
    rst_addr = 32'h0000_0F80;
`else
    rst_len  = 8'd3;
    rst_addr = 32'h0000_5000;
`endif
    push(rst_len, rst_addr);
    wait_pop("rstm_pop");
    repeat (2) @(negedge clk);
    check_val("rstm_valid", {63'd0, m_arvalid}, 64'd1);
    check_val("rstm_addr", {32'd0, m_araddr}, {32'd0, rst_addr});
    hs0 = hs_n;
    #2 rd_rst = 1'b1;
    #1;
    check_val("rstm_valid_async", {63'd0, m_arvalid}, 64'd0);
    check_val("rstm_busy_async", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rd_rst    = 1'b0;
    m_arready = 1'b1;
    repeat (8) @(negedge clk);
    check_val("rstm_no_issue", 64'(hs_n - hs0), 64'd0);
    check_val("rstm_valid_after", {63'd0, m_arvalid}, 64'd0);
    check_val("rstm_outstanding", {60'd0, outstanding}, 64'd0);
    check_val("rstm_busy", {63'd0, busy}, 64'd0);

    check_val("pop_while_empty", 64'(pop_empty_n), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
